sr_debounce_ctrl: RTL and testbench
===================================

// Module: sr_debounce_ctrl
// PURPOSE
//   Front-end stage for the cross-coupled NAND SR latch. Takes two raw, bouncy,
//   asynchronous push-button levels (set, reset) and drives the latch's
//   active-low inputs with clean, mutually exclusive, fixed-width pulses.
//   Also keeps a registered model of the latch state. Its outputs connect
//   directly to the latch's set_n/reset_n inputs, so the forbidden 0/0
//   condition never reaches the latch.
// PARAMETERS
//   DEBOUNCE_CYCLES  4  consecutive stable cycles needed to accept a new level (>=1)
//   PULSE_LEN        2  cycles the active-low pulse is held low (>=1)
// PORTS
//   clk        in   1  rising-edge clock
//   reset      in   1  asynchronous, active-high reset
//   set_btn    in   1  raw set request, asynchronous, may bounce
//   reset_btn  in   1  raw reset request, asynchronous, may bounce
//   set_n      out  1  active-low set pulse to the latch (idle 1)
//   reset_n    out  1  active-low reset pulse to the latch (idle 1)
//   q_model    out  1  expected latch q after the current/last pulse
//   conflict   out  1  one-cycle flag: a request was dropped
// BEHAVIOUR
//   Reset (async, on reset=1): set_n=1, reset_n=1, q_model=0, conflict=0.
//     Sync flops, debounced levels and counters are 0. FSM is in IDLE.
//     No pulse is issued on reset release, even if a button is held.
//   Sync: each button passes through a 2-flop synchronizer (sync1 -> sync2).
//   Debounce (per channel): a counter of width $clog2(DEBOUNCE_CYCLES+1).
//     - Clears on any edge where sync2 == deb.
//     - Otherwise increments.
//     - On the edge where it would reach DEBOUNCE_CYCLES, deb <= sync2 and the
//       counter clears.
//   Edge detect: req = deb & ~deb_d (rising edge only). Falling edges are ignored.
//   FSM states: IDLE, SET_PULSE, RST_PULSE. Pulse counter counts to PULSE_LEN.
//     IDLE, set req only   -> SET_PULSE: set_n<=0, q_model<=1.
//     IDLE, reset req only -> RST_PULSE: reset_n<=0, q_model<=0.
//     IDLE, both reqs same cycle -> stay IDLE, no pulse, conflict<=1 for 1 cycle.
//     In a PULSE state: after PULSE_LEN low cycles, output <=1 and go to IDLE.
//     Any req that arrives in a PULSE state is dropped, with conflict<=1 for
//       1 cycle. It is not queued.
//   Invariant: set_n and reset_n are never 0 in the same cycle.
//   Latency: raw rise held stable before edge E0 -> set_n falls after edge
//     E(DEBOUNCE_CYCLES+3). With defaults that is the 7th edge.
//   Glitch rejection: a sync2 excursion shorter than DEBOUNCE_CYCLES cycles
//     produces no pulse and leaves deb unchanged.
//   Reset mid-pulse: outputs return to the reset values immediately (async).
//     The pulse is not resumed after reset is released.
//   All outputs are registered. No combinational path from inputs to outputs.
// TESTING
//   1 Clean press: set_btn 0->1 held 20 cycles -> set_n low exactly 2 cycles
//     starting 7 edges after the rise; q_model=1; reset_n stays 1; conflict=0.
//   2 Bounce: set_btn toggles 1,0,1 with 2-cycle widths, then stays 1 ->
//     exactly one set_n pulse, only after 4 stable sync2 cycles.
//   3 Glitch: reset_btn high for 3 cycles, then 0 -> no reset_n pulse,
//     q_model unchanged, conflict=0.
//   4 Simultaneous: set_btn and reset_btn rise on the same edge, held ->
//     no pulse on either output; conflict=1 for exactly 1 cycle.
//   5 Overlap: reset deb rises during SET_PULSE (PULSE_LEN=4) -> set pulse
//     completes its 4 cycles, reset is dropped, conflict=1 for 1 cycle,
//     q_model stays 1.
//   6 Async reset: assert reset between edges during SET_PULSE -> set_n=1 and
//     q_model=0 before the next edge; no pulse after release while set_btn
//     stays held.

Source files
------------

// File: rtl/sr_debounce_ctrl.sv
// rtl/sr_debounce_ctrl.sv - debounced, mutually exclusive set/reset pulse driver for a NAND SR latch
module sr_debounce_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_LEN       = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic set_btn,
    input  logic reset_btn,
    output logic set_n,
    output logic reset_n,
    output logic q_model,
    output logic conflict
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(PULSE_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        SET_PULSE,
        RST_PULSE
    } state_t;

    // Channel index 0 is set, 1 is reset.
    logic [1:0]    btn;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    deb_q;
    logic [1:0]    deb_dly_q;
    logic [1:0]    armed_q;
    logic [1:0]    req_q;
    logic [1:0]    fill_q;
    logic          fill_done;
    logic [DW-1:0] cnt_q [2];

    state_t        state_q, state_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          set_n_q, set_n_d;
    logic          reset_n_q, reset_n_d;
    logic          q_model_q, q_model_d;
    logic          conflict_q, conflict_d;

    assign btn       = {reset_btn, set_btn};
    assign fill_done = (fill_q == 2'd2);

    // A channel arms only once its debounced level agrees with a filled synchronizer,
    // so a button held through reset is absorbed silently instead of producing a pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_dly_q <= '0;
            armed_q   <= '0;
            req_q     <= '0;
            fill_q    <= '0;
        end else begin
            sync1_q   <= btn;
            sync2_q   <= sync1_q;
            deb_dly_q <= deb_q;
            armed_q   <= armed_q | ({2{fill_done}} & ~(sync2_q ^ deb_q));
            req_q     <= armed_q & deb_q & ~deb_dly_q;
            if (!fill_done) begin
                fill_q <= fill_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_q <= '0;
            for (int c = 0; c < 2; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (sync2_q[c] == deb_q[c]) begin
                    cnt_q[c] <= '0;
                end else if (cnt_q[c] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_q[c] <= sync2_q[c];
                    cnt_q[c] <= '0;
                end else begin
                    cnt_q[c] <= cnt_q[c] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pcnt_q     <= '0;
            set_n_q    <= 1'b1;
            reset_n_q  <= 1'b1;
            q_model_q  <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            set_n_q    <= set_n_d;
            reset_n_q  <= reset_n_d;
            q_model_q  <= q_model_d;
            conflict_q <= conflict_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        set_n_d    = set_n_q;
        reset_n_d  = reset_n_q;
        q_model_d  = q_model_q;
        conflict_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_q == 2'b11) begin
                    conflict_d = 1'b1;
                end else if (req_q[0]) begin
                    state_d   = SET_PULSE;
                    set_n_d   = 1'b0;
                    q_model_d = 1'b1;
                    pcnt_d    = PW'(1);
                end else if (req_q[1]) begin
                    state_d   = RST_PULSE;
                    reset_n_d = 1'b0;
                    q_model_d = 1'b0;
                    pcnt_d    = PW'(1);
                end
            end
            SET_PULSE, RST_PULSE: begin
                // Requests during a pulse are dropped, never queued.
                if (|req_q) begin
                    conflict_d = 1'b1;
                end
                if (pcnt_q == PW'(PULSE_LEN)) begin
                    state_d   = IDLE;
                    set_n_d   = 1'b1;
                    reset_n_d = 1'b1;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                set_n_d   = 1'b1;
                reset_n_d = 1'b1;
            end
        endcase
    end

    assign set_n    = set_n_q;
    assign reset_n  = reset_n_q;
    assign q_model  = q_model_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_debounce_ctrl.sv
// tb/tb_sr_debounce_ctrl.sv - directed self-checking bench for sr_debounce_ctrl
module tb_sr_debounce_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic set_btn;
    logic reset_btn;
    logic s2, r2, q2, c2;
    logic s4, r4, q4, c4;

    int n_tests = 0;
    int n_fail  = 0;

    int s_first, s_low, r_low, cf, cf_first;
    int s4_low, r4_low, cf4;
    int both_low = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ZERO = 64'h0;

    sr_debounce_ctrl #(.DEBOUNCE_CYCLES(4), .PULSE_LEN(2)) u_dut (
        .clk       (clk),
        .reset     (rst),
        .set_btn   (set_btn),
        .reset_btn (reset_btn),
        .set_n     (s2),
        .reset_n   (r2),
        .q_model   (q2),
        .conflict  (c2)
    );

    sr_debounce_ctrl #(.DEBOUNCE_CYCLES(4), .PULSE_LEN(4)) u_dut4 (
        .clk       (clk),
        .reset     (rst),
        .set_btn   (set_btn),
        .reset_btn (reset_btn),
        .set_n     (s4),
        .reset_n   (r4),
        .q_model   (q4),
        .conflict  (c4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Bit i of sp/rp is the button level applied before edge i; outputs sampled 1ns after it.
    task automatic window(input int n, input logic [63:0] sp, input logic [63:0] rp);
        s_first  = -1;
        cf_first = -1;
        s_low    = 0;
        r_low    = 0;
        cf       = 0;
        s4_low   = 0;
        r4_low   = 0;
        cf4      = 0;
        for (int i = 0; i < n; i++) begin
            set_btn   = sp[i];
            reset_btn = rp[i];
            @(posedge clk);
            #1;
            if (!s2) begin
                s_low++;
                if (s_first < 0) s_first = i;
            end
            if (!r2) r_low++;
            if (c2) begin
                cf++;
                if (cf_first < 0) cf_first = i;
            end
            if (!s4) s4_low++;
            if (!r4) r4_low++;
            if (c4) cf4++;
            if ((!s2 && !r2) || (!s4 && !r4)) both_low++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        set_btn   = 1'b0;
        reset_btn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_set_n", s2, 1);
        check("rst_reset_n", r2, 1);
        check("rst_q_model", q2, 0);
        check("rst_conflict", c2, 0);
        rst = 1'b0;
        window(10, ZERO, ZERO);
        check("idle_no_pulse", s_low + r_low, 0);

        // clean press
        window(20, ONES, ZERO);
        check("t1_first_low_edge", s_first, 7);
        check("t1_low_cycles", s_low, 2);
        check("t1_reset_n_idle", r_low, 0);
        check("t1_conflict", cf, 0);
        check("t1_q_model", q2, 1);
        window(10, ZERO, ZERO);
        check("t1_fall_ignored", s_low + r_low, 0);

        // bounce 1,0,1 then steady high
        window(20, 64'hFFFF_FFFF_FFFF_FFF3, ZERO);
        check("t2_first_low_edge", s_first, 11);
        check("t2_single_pulse", s_low, 2);
        check("t2_conflict", cf, 0);
        window(10, ZERO, ZERO);

        // 3-cycle glitch on reset
        window(20, ZERO, 64'h7);
        check("t3_no_reset_pulse", r_low, 0);
        check("t3_q_model", q2, 1);
        check("t3_conflict", cf, 0);

        // simultaneous press
        window(20, ONES, ONES);
        check("t4_no_set_pulse", s_low, 0);
        check("t4_no_reset_pulse", r_low, 0);
        check("t4_conflict_cycles", cf, 1);
        check("t4_conflict_edge", cf_first, 7);
        window(15, ZERO, ZERO);
        check("t4_release_quiet", s_low + r_low + cf, 0);

        // reset request lands inside a 4-cycle set pulse
        window(20, ONES, 64'hFFFF_FFFF_FFFF_FFFC);
        check("t5_set_low_cycles", s4_low, 4);
        check("t5_reset_dropped", r4_low, 0);
        check("t5_conflict_cycles", cf4, 1);
        check("t5_q_model", q4, 1);
        window(15, ZERO, ZERO);

        // async reset mid-pulse
        set_btn   = 1'b1;
        reset_btn = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        check("t6_pulse_active", s2, 0);
        #2;
        rst = 1'b1;
        #1;
        check("t6_set_n_async", s2, 1);
        check("t6_q_model_async", q2, 0);
        check("t6_reset_n_async", r2, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        window(20, ONES, ZERO);
        check("t6_no_resume", s_low + r_low, 0);
        check("t6_conflict", cf, 0);
        check("t6_q_model", q2, 0);

        check("never_both_low", both_low, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
